// File: rtl/cpu_trace_buffer.sv
// Retirement trace buffer: turns the CPU's observation strobes into one trace record
// per architectural event and queues them in a first-word-fall-through FIFO.
module cpu_trace_buffer #(
  parameter int DEPTH  = 16,
  parameter int DROP_W = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     ld_ir,
  input  logic [63:0]              pc,
  input  logic [31:0]              instruction,
  input  logic                     reg_wr,
  input  logic [63:0]              wb_data,
  input  logic                     memoria_wr,
  input  logic [63:0]              mem_addr,
  input  logic [63:0]              mem_wdata,
  input  logic                     exc,
  input  logic [7:0]               causa,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [1:0]               out_kind,
  output logic [63:0]              out_pc,
  output logic [31:0]              out_instr,
  output logic [63:0]              out_data,
  output logic [63:0]              out_addr,
  output logic [$clog2(DEPTH):0]   count,
  output logic [DROP_W-1:0]        drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]       FULL_CNT = (AW + 1)'(DEPTH);
  localparam logic [DROP_W-1:0] DROP_MAX = {DROP_W{1'b1}};

  localparam logic [1:0] KIND_REG = 2'b00;
  localparam logic [1:0] KIND_ST  = 2'b01;
  localparam logic [1:0] KIND_EXC = 2'b10;

  typedef struct packed {
    logic [1:0]  kind;
    logic [63:0] pc;
    logic [31:0] instr;
    logic [63:0] data;
    logic [63:0] addr;
  } rec_t;

  // Context of the instruction currently in IR; records are tagged with this, not live pc.
  logic [63:0]       r_cur_pc;
  logic [31:0]       r_cur_instr;

  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [AW:0]       r_count;
  logic [DROP_W-1:0] r_drop_cnt;
  rec_t              r_mem [DEPTH];

  logic [4:0]        w_rd;
  logic              w_rw_ev;
  logic              w_event;
  logic [1:0]        w_loss;
  rec_t              w_rec;
  logic              w_full;
  logic              w_pop;
  logic              w_push;
  logic              w_discard;
  logic [1:0]        w_drop_inc;
  logic [DROP_W+1:0] w_drop_sum;
  logic [AW:0]       w_count_next;
  logic [DROP_W-1:0] w_drop_next;
  rec_t              w_head;

  assign w_rd    = r_cur_instr[11:7];
  assign w_rw_ev = reg_wr && (w_rd != 5'd0);

  // Event selection: exception beats store beats register write; losers are counted as drops.
  always_comb begin
    w_rec       = '0;
    w_event     = 1'b0;
    w_loss      = 2'd0;
    w_rec.pc    = r_cur_pc;
    w_rec.instr = r_cur_instr;
    if (enable) begin
      if (exc) begin
        w_event    = 1'b1;
        w_rec.kind = KIND_EXC;
        w_rec.data = {56'b0, causa};
        w_rec.addr = 64'b0;
        w_loss     = {1'b0, memoria_wr} + {1'b0, w_rw_ev};
      end else if (memoria_wr) begin
        w_event    = 1'b1;
        w_rec.kind = KIND_ST;
        w_rec.data = mem_wdata;
        w_rec.addr = mem_addr;
        w_loss     = {1'b0, w_rw_ev};
      end else if (w_rw_ev) begin
        w_event    = 1'b1;
        w_rec.kind = KIND_REG;
        w_rec.data = wb_data;
        w_rec.addr = {59'b0, w_rd};
      end
    end
  end

  assign w_full     = (r_count == FULL_CNT);
  assign w_pop      = (r_count != '0) && out_ready;
  assign w_push     = w_event && (!w_full || w_pop);
  assign w_discard  = w_event && !w_push;
  assign w_drop_inc = w_loss + {1'b0, w_discard};

  // Widened sum so the saturation test cannot itself overflow.
  assign w_drop_sum  = {2'b00, r_drop_cnt} + {{DROP_W{1'b0}}, w_drop_inc};
  assign w_drop_next = (w_drop_sum > {2'b00, DROP_MAX}) ? DROP_MAX : w_drop_sum[DROP_W-1:0];

  always_comb begin
    w_count_next = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_next = r_count + (AW + 1)'(1);
      2'b01:   w_count_next = r_count - (AW + 1)'(1);
      default: w_count_next = r_count;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cur_pc    <= 64'b0;
      r_cur_instr <= 32'b0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_drop_cnt  <= '0;
    end else begin
      if (ld_ir) begin
        r_cur_pc    <= pc;
        r_cur_instr <= instruction;
      end
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      r_count    <= w_count_next;
      r_drop_cnt <= w_drop_next;
    end
  end

  // Storage carries no reset; validity is tracked entirely by r_count.
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_rec;
    end
  end

  assign w_head = r_mem[r_rd_ptr];

  always_comb begin
    out_valid = (r_count != '0);
    out_kind  = out_valid ? w_head.kind  : 2'b00;
    out_pc    = out_valid ? w_head.pc    : 64'b0;
    out_instr = out_valid ? w_head.instr : 32'b0;
    out_data  = out_valid ? w_head.data  : 64'b0;
    out_addr  = out_valid ? w_head.addr  : 64'b0;
  end

  assign count    = r_count;
  assign drop_cnt = r_drop_cnt;

endmodule

// File: tb/tb_cpu_trace_buffer.sv
// Bench for cpu_trace_buffer: directed stimulus pushes expected records into a queue,
// a negedge monitor pops and compares every record the DUT hands over.
module tb_cpu_trace_buffer;

  logic        clock = 1'b0;
  logic        reset;
  logic        enable;
  logic        ld_ir;
  logic [63:0] pc;
  logic [31:0] instruction;
  logic        reg_wr;
  logic [63:0] wb_data;
  logic        memoria_wr;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic        exc;
  logic [7:0]  causa;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_kind;
  logic [63:0] out_pc;
  logic [31:0] out_instr;
  logic [63:0] out_data;
  logic [63:0] out_addr;
  logic [4:0]  count;
  logic [15:0] drop_cnt;

  always #5 clock = ~clock;

  cpu_trace_buffer #(.DEPTH(16), .DROP_W(16)) dut (
    .clock(clock), .reset(reset), .enable(enable), .ld_ir(ld_ir), .pc(pc),
    .instruction(instruction), .reg_wr(reg_wr), .wb_data(wb_data),
    .memoria_wr(memoria_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .exc(exc), .causa(causa), .out_valid(out_valid), .out_ready(out_ready),
    .out_kind(out_kind), .out_pc(out_pc), .out_instr(out_instr),
    .out_data(out_data), .out_addr(out_addr), .count(count), .drop_cnt(drop_cnt)
  );

  typedef struct packed {
    logic [1:0]  kind;
    logic [63:0] pc;
    logic [31:0] instr;
    logic [63:0] data;
    logic [63:0] addr;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: a handshake seen here completes at the next rising edge.
  always @(negedge clock) begin
    if (!reset && out_valid && out_ready) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL unexpected_record: got kind=%0d pc=0x%0h data=0x%0h, expected none",
                 out_kind, out_pc, out_data);
      end else begin
        mon_e = exp_q.pop_front();
        if (out_kind !== mon_e.kind || out_pc !== mon_e.pc || out_instr !== mon_e.instr ||
            out_data !== mon_e.data || out_addr !== mon_e.addr) begin
          n_errors++;
          $display("FAIL record: got kind=%0d pc=0x%0h instr=0x%0h data=0x%0h addr=0x%0h expected kind=%0d pc=0x%0h instr=0x%0h data=0x%0h addr=0x%0h",
                   out_kind, out_pc, out_instr, out_data, out_addr,
                   mon_e.kind, mon_e.pc, mon_e.instr, mon_e.data, mon_e.addr);
        end else begin
          $display("pop kind=%0d pc=0x%0h instr=0x%0h data=0x%0h addr=0x%0h ok",
                   out_kind, out_pc, out_instr, out_data, out_addr);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clr();
    ld_ir = 1'b0; reg_wr = 1'b0; memoria_wr = 1'b0; exc = 1'b0;
  endtask

  task automatic fetch(input logic [63:0] p, input logic [31:0] i);
    ld_ir = 1'b1; pc = p; instruction = i;
    tick();
    ld_ir = 1'b0;
  endtask

  task automatic rw(input logic [63:0] d);
    reg_wr = 1'b1; wb_data = d;
    tick();
    reg_wr = 1'b0;
  endtask

  task automatic push_exp(input logic [1:0] k, input logic [63:0] p, input logic [31:0] i,
                          input logic [63:0] d, input logic [63:0] a);
    exp_t e;
    e.kind = k; e.pc = p; e.instr = i; e.data = d; e.addr = a;
    exp_q.push_back(e);
  endtask

  task automatic drain_wait(input string name);
    bit done;
    done = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 200; c++) begin
      if (exp_q.size() == 0 && out_valid == 1'b0) begin
        done = 1'b1;
        break;
      end
      tick();
    end
    chk({name, "_drained"}, {63'b0, done}, 64'd1);
    chk({name, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
    chk({name, "_count0"}, {59'b0, count}, 64'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    exp_q.delete();
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; enable = 1'b1; out_ready = 1'b0; clr();
    pc = '0; instruction = '0; wb_data = '0; mem_addr = '0; mem_wdata = '0; causa = '0;
    #2;
    chk("rst_valid", {63'b0, out_valid}, 64'd0);
    chk("rst_count", {59'b0, count}, 64'd0);
    chk("rst_drop", {48'b0, drop_cnt}, 64'd0);
    chk("rst_pc", out_pc, 64'd0);
    chk("rst_data", out_data, 64'd0);
    tick(); tick();
    reset = 1'b0;
    tick();

    // Basic register-write record and one-cycle latency.
    fetch(64'h40, 32'h00500093);
    chk("t1_pre_valid", {63'b0, out_valid}, 64'd0);
    push_exp(2'b00, 64'h40, 32'h00500093, 64'd5, 64'd1);
    rw(64'd5);
    chk("t1_latency_valid", {63'b0, out_valid}, 64'd1);
    chk("t1_count", {59'b0, count}, 64'd1);
    drain_wait("t1");

    // rd=0 write is not an event; store record follows.
    fetch(64'h44, 32'h00000013);
    rw(64'd7);
    chk("t2_rd0_count", {59'b0, count}, 64'd0);
    chk("t2_rd0_drop", {48'b0, drop_cnt}, 64'd0);
    push_exp(2'b01, 64'h44, 32'h00000013, 64'hAB, 64'h100);
    memoria_wr = 1'b1; mem_addr = 64'h100; mem_wdata = 64'hAB;
    tick();
    clr();
    drain_wait("t2_store");

    // Disabled capture: events ignored, context still latched.
    enable = 1'b0;
    fetch(64'hC0, 32'h00B00593);
    exc = 1'b1; causa = 8'd4; memoria_wr = 1'b1; reg_wr = 1'b1; wb_data = 64'h66;
    tick();
    clr();
    chk("en0_count", {59'b0, count}, 64'd0);
    chk("en0_drop", {48'b0, drop_cnt}, 64'd0);
    enable = 1'b1;
    // Fetch and event in the same cycle: record carries the previous context.
    push_exp(2'b00, 64'hC0, 32'h00B00593, 64'h88, 64'd11);
    ld_ir = 1'b1; pc = 64'hD0; instruction = 32'h00C00613; reg_wr = 1'b1; wb_data = 64'h88;
    tick();
    clr();
    push_exp(2'b00, 64'hD0, 32'h00C00613, 64'h99, 64'd12);
    rw(64'h99);
    drain_wait("t2_ctx");

    // Priority: exception wins, two losers counted.
    fetch(64'h48, 32'h00208133);
    push_exp(2'b10, 64'h48, 32'h00208133, 64'd2, 64'd0);
    exc = 1'b1; causa = 8'd2; memoria_wr = 1'b1; mem_addr = 64'h200; mem_wdata = 64'h55;
    reg_wr = 1'b1; wb_data = 64'd9;
    tick();
    clr();
    chk("t3_drop", {48'b0, drop_cnt}, 64'd2);
    drain_wait("t3");

    do_reset();
    chk("rst2_drop", {48'b0, drop_cnt}, 64'd0);

    // Overflow, full with simultaneous pop, drain across pointer wrap.
    out_ready = 1'b0;
    fetch(64'h80, 32'h00A00513);
    for (int i = 0; i < 16; i++) begin
      push_exp(2'b00, 64'h80, 32'h00A00513, 64'h1000 + 64'(i), 64'd10);
      rw(64'h1000 + 64'(i));
    end
    chk("t4_full_count", {59'b0, count}, 64'd16);
    chk("t4_full_drop", {48'b0, drop_cnt}, 64'd0);
    for (int j = 0; j < 3; j++) rw(64'h2000 + 64'(j));
    chk("t4_ovf_count", {59'b0, count}, 64'd16);
    chk("t4_ovf_drop", {48'b0, drop_cnt}, 64'd3);
    push_exp(2'b00, 64'h80, 32'h00A00513, 64'h3000, 64'd10);
    reg_wr = 1'b1; wb_data = 64'h3000; out_ready = 1'b1;
    tick();
    reg_wr = 1'b0;
    chk("t4_pushpop_count", {59'b0, count}, 64'd16);
    chk("t4_pushpop_drop", {48'b0, drop_cnt}, 64'd3);
    drain_wait("t4");

    // Drop counter saturation: full FIFO plus three-way collision = 3 drops/cycle.
    out_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      push_exp(2'b00, 64'h80, 32'h00A00513, 64'h4000 + 64'(i), 64'd10);
      rw(64'h4000 + 64'(i));
    end
    chk("t5_full_count", {59'b0, count}, 64'd16);
    exc = 1'b1; causa = 8'd3; memoria_wr = 1'b1; reg_wr = 1'b1; wb_data = 64'd1;
    repeat (100) tick();
    chk("t5_drop_303", {48'b0, drop_cnt}, 64'd303);
    repeat (21900) tick();
    chk("t5_drop_sat", {48'b0, drop_cnt}, 64'hFFFF);
    tick();
    chk("t5_drop_hold", {48'b0, drop_cnt}, 64'hFFFF);
    chk("t5_count_hold", {59'b0, count}, 64'd16);
    clr();
    do_reset();

    // Asynchronous reset in the middle of a drain.
    out_ready = 1'b0;
    fetch(64'h300, 32'h00100093);
    for (int i = 0; i < 4; i++) begin
      push_exp(2'b00, 64'h300, 32'h00100093, 64'h5000 + 64'(i), 64'd1);
      rw(64'h5000 + 64'(i));
    end
    push_exp(2'b01, 64'h300, 32'h00100093, 64'hEE, 64'h180);
    memoria_wr = 1'b1; mem_addr = 64'h180; mem_wdata = 64'hEE; reg_wr = 1'b1; wb_data = 64'h77;
    tick();
    clr();
    chk("t6_fill_count", {59'b0, count}, 64'd5);
    chk("t6_fill_drop", {48'b0, drop_cnt}, 64'd1);
    out_ready = 1'b1;
    tick(); tick();
    chk("t6_mid_count", {59'b0, count}, 64'd3);
    #1;
    reset = 1'b1;
    exp_q.delete();
    #1;
    chk("t6_arst_valid", {63'b0, out_valid}, 64'd0);
    chk("t6_arst_count", {59'b0, count}, 64'd0);
    chk("t6_arst_drop", {48'b0, drop_cnt}, 64'd0);
    chk("t6_arst_kind", {62'b0, out_kind}, 64'd0);
    chk("t6_arst_pc", out_pc, 64'd0);
    chk("t6_arst_instr", {32'b0, out_instr}, 64'd0);
    chk("t6_arst_data", out_data, 64'd0);
    chk("t6_arst_addr", out_addr, 64'd0);
    tick();
    reset = 1'b0;
    // Context was cleared: rd=0, so a register write yields nothing.
    rw(64'h123);
    chk("t6_ctx_clear_count", {59'b0, count}, 64'd0);
    push_exp(2'b01, 64'd0, 32'd0, 64'h11, 64'h20);
    memoria_wr = 1'b1; mem_addr = 64'h20; mem_wdata = 64'h11;
    tick();
    clr();
    drain_wait("t6_ctx_store");
    out_ready = 1'b0;
    fetch(64'h310, 32'h00100093);
    push_exp(2'b00, 64'h310, 32'h00100093, 64'h600, 64'd1);
    rw(64'h600);
    chk("t6_post_valid", {63'b0, out_valid}, 64'd1);
    chk("t6_post_count", {59'b0, count}, 64'd1);
    drain_wait("t6_post");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
